// File: rtl/rgbled_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rgbled_ctrl : per-LED colour store and frame sequencer for ws281x_drv
// Rev 1.0
// ---------------------------------------------------------------------------
module rgbled_ctrl #(
  parameter int NumLeds     = 2,
  parameter int LatchCycles = 1600,
  parameter int IdxW        = (NumLeds > 1) ? $clog2(NumLeds) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cfg_we_i,
  input  logic [IdxW-1:0] cfg_idx_i,
  input  logic [23:0]     cfg_rgb_i,
  input  logic            update_i,
  input  logic            off_i,
  output logic            busy_o,
  output logic            ws_go_o,
  input  logic            ws_idle_i,
  output logic [23:0]     ws_data_o,
  output logic            ws_data_valid_o,
  output logic            ws_data_last_o,
  input  logic            ws_data_ack_i
);

  localparam int CntW  = (LatchCycles > 1) ? $clog2(LatchCycles) : 1;
  localparam int IdxW1 = IdxW + 1;

  localparam logic [IdxW:0]   c_num_leds = IdxW1'(NumLeds);
  localparam logic [IdxW-1:0] c_last_idx = IdxW'(NumLeds - 1);
  localparam logic [CntW-1:0] c_cnt_max  = CntW'(LatchCycles - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pend_off_q, pend_off_d;
  logic            pend_upd_q, pend_upd_d;
  logic [23:0]     colour_q [NumLeds];
  logic [23:0]     colour_d [NumLeds];
  logic [23:0]     shadow_q [NumLeds];
  logic [23:0]     shadow_d [NumLeds];
  logic            busy_q, busy_d;
  logic            go_q, go_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic [23:0]     data_q, data_d;
  logic [23:0]     w_word;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    pend_off_d = pend_off_q;
    pend_upd_d = pend_upd_q;
    colour_d   = colour_q;
    shadow_d   = shadow_q;

    if (cfg_we_i && ({1'b0, cfg_idx_i} < c_num_leds)) begin
      colour_d[cfg_idx_i] = cfg_rgb_i;
    end

    case (state_q)
      S_IDLE: begin
        if ((pend_off_q || pend_upd_q) && ws_idle_i) begin
          // Snapshot the frame so later colour writes cannot tear it.
          for (int i = 0; i < NumLeds; i++) begin
            shadow_d[i] = pend_upd_q ? colour_q[i] : 24'h000000;
          end
          pend_off_d = 1'b0;
          pend_upd_d = 1'b0;
          idx_d      = '0;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (ws_data_ack_i) begin
          if (idx_q == c_last_idx) begin
            cnt_d   = '0;
            state_d = S_LATCH;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_LATCH: begin
        if (!ws_idle_i) begin
          cnt_d = '0;
        end else if (cnt_q == c_cnt_max) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Applied after the start clear so a same-cycle request stays pending; off wins.
    if (update_i) begin
      pend_upd_d = 1'b1;
      pend_off_d = 1'b0;
    end
    if (off_i) begin
      pend_off_d = 1'b1;
      pend_upd_d = 1'b0;
    end

    w_word  = shadow_d[idx_d];
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_SEND);
    go_d    = valid_d;
    last_d  = valid_d && (idx_d == c_last_idx);
    data_d  = valid_d ? {w_word[15:8], w_word[23:16], w_word[7:0]} : 24'h000000;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      pend_off_q <= 1'b1;
      pend_upd_q <= 1'b0;
      colour_q   <= '{default: 24'h000000};
      shadow_q   <= '{default: 24'h000000};
      busy_q     <= 1'b0;
      go_q       <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= 24'h000000;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      pend_off_q <= pend_off_d;
      pend_upd_q <= pend_upd_d;
      colour_q   <= colour_d;
      shadow_q   <= shadow_d;
      busy_q     <= busy_d;
      go_q       <= go_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      data_q     <= data_d;
    end
  end

  assign busy_o          = busy_q;
  assign ws_go_o         = go_q;
  assign ws_data_valid_o = valid_q;
  assign ws_data_last_o  = last_q;
  assign ws_data_o       = data_q;

endmodule
`default_nettype wire

// File: tb/tb_rgbled_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rgbled_ctrl : vector-table bench for rgbled_ctrl with a ws281x driver model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_rgbled_ctrl;

  localparam int NLEDS    = 2;
  localparam int LAT      = 8;
  localparam int IW       = 2;
  localparam int ACK_WAIT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [23:0]   cfg_rgb = '0;
  logic          update = 1'b0;
  logic          off = 1'b0;
  logic          busy, go, valid, last;
  logic [23:0]   data;
  logic          ws_idle = 1'b1;
  logic          ws_ack = 1'b0;

  always #5 clk = ~clk;

  rgbled_ctrl #(
    .NumLeds    (NLEDS),
    .LatchCycles(LAT),
    .IdxW       (IW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cfg_we_i       (cfg_we),
    .cfg_idx_i      (cfg_idx),
    .cfg_rgb_i      (cfg_rgb),
    .update_i       (update),
    .off_i          (off),
    .busy_o         (busy),
    .ws_go_o        (go),
    .ws_idle_i      (ws_idle),
    .ws_data_o      (data),
    .ws_data_valid_o(valid),
    .ws_data_last_o (last),
    .ws_data_ack_i  (ws_ack)
  );

  int vecs  = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int          n;
    logic [23:0] w0;
    logic [23:0] w1;
    logic        l0;
    logic        l1;
  } frame_t;

  frame_t      frames[$];
  frame_t      cur = '{n: 0, w0: '0, w1: '0, l0: 1'b0, l1: 1'b0};
  int          wait_cnt = 0;
  int          idle_edges = 0;
  int          tail_t = 0;
  bit          latch_phase = 1'b0;
  bit          glitch = 1'b0;
  logic [24:0] held = '0;

  // Driver model: acks each word after ACK_WAIT extra cycles, stays busy a few
  // cycles after the last word, and optionally bounces idle during the gap.
  always @(negedge clk) begin
    if (rst) begin
      ws_idle     = 1'b1;
      ws_ack      = 1'b0;
      wait_cnt    = 0;
      latch_phase = 1'b0;
      cur.n       = 0;
    end else begin
      ws_ack = 1'b0;
      if (latch_phase) begin
        if (ws_idle) idle_edges++;
        else idle_edges = 0;
        if (!busy) begin
          chk("latch_gap_idle_edges", idle_edges, LAT);
          latch_phase = 1'b0;
          ws_idle     = 1'b1;
        end else begin
          tail_t++;
          ws_idle = (tail_t >= 3) && !(glitch && tail_t >= 6 && tail_t < 8);
        end
      end
      if (valid) begin
        ws_idle = 1'b0;
        if (wait_cnt == 0) begin
          held = {last, data};
          chk("busy_in_send", busy, 1);
          chk("go_with_valid", go, 1);
        end else begin
          chk("word_held_until_ack", {last, data}, held);
        end
        if (wait_cnt == ACK_WAIT) begin
          ws_ack   = 1'b1;
          wait_cnt = 0;
          if (cur.n == 0) begin
            cur.w0 = data;
            cur.l0 = last;
          end else if (cur.n == 1) begin
            cur.w1 = data;
            cur.l1 = last;
          end
          cur.n++;
          if (last) begin
            frames.push_back(cur);
            cur.n       = 0;
            latch_phase = 1'b1;
            tail_t      = 0;
            idle_edges  = 0;
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic step(input logic we, input logic [IW-1:0] idx, input logic [23:0] rgb,
                      input logic u, input logic o);
    cfg_we  = we;
    cfg_idx = idx;
    cfg_rgb = rgb;
    update  = u;
    off     = o;
    @(negedge clk); #1;
    cfg_we = 1'b0;
    update = 1'b0;
    off    = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk); #1;
      done = (frames.size() >= target) && !busy;
    end
    chk("frame_done_in_time", done, 1);
  endtask

  task automatic wait_word(input bit need_last);
    bit done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk); #1;
      done = valid && (!need_last || last);
    end
    chk("word_seen_in_time", done, 1);
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic check_frame(input string tag, input int k, input logic [23:0] e0,
                             input logic [23:0] e1);
    frame_t f;
    if (k >= frames.size()) begin
      chk({tag, "_present"}, frames.size(), k + 1);
      return;
    end
    f = frames[k];
    chk({tag, "_nwords"}, f.n, NLEDS);
    chk({tag, "_word0"}, f.w0, e0);
    chk({tag, "_word1"}, f.w1, e1);
    chk({tag, "_last0"}, f.l0, 0);
    chk({tag, "_last1"}, f.l1, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_go"}, go, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_last"}, last, 0);
    chk({tag, "_data"}, data, 0);
  endtask

  typedef struct {
    logic          we0;
    logic [IW-1:0] i0;
    logic [23:0]   c0;
    logic          we1;
    logic [IW-1:0] i1;
    logic [23:0]   c1;
    logic          upd;
    logic          offr;
    logic [23:0]   e0;
    logic [23:0]   e1;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int base;
    tbl[0] = '{1'b1, 2'd0, 24'hFF0000, 1'b1, 2'd1, 24'h00FF00, 1'b1, 1'b0, 24'h00FF00, 24'hFF0000};
    tbl[1] = '{1'b0, 2'd0, 24'h000000, 1'b0, 2'd0, 24'h000000, 1'b0, 1'b1, 24'h000000, 24'h000000};
    tbl[2] = '{1'b1, 2'd3, 24'h123456, 1'b0, 2'd0, 24'h000000, 1'b1, 1'b0, 24'h00FF00, 24'hFF0000};
    tbl[3] = '{1'b0, 2'd0, 24'h000000, 1'b0, 2'd0, 24'h000000, 1'b1, 1'b1, 24'h000000, 24'h000000};
    tbl[4] = '{1'b1, 2'd0, 24'h123456, 1'b1, 2'd1, 24'hABCDEF, 1'b1, 1'b0, 24'h341256, 24'hCDABEF};
    tbl[5] = '{1'b1, 2'd1, 24'h0000FF, 1'b0, 2'd0, 24'h000000, 1'b1, 1'b0, 24'h341256, 24'h0000FF};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // Automatic zero frame after reset.
    wait_frames(1);
    check_frame("post_reset", 0, 24'h000000, 24'h000000);

    for (int v = 0; v < 6; v++) begin
      base = frames.size();
      if (tbl[v].we0) step(1'b1, tbl[v].i0, tbl[v].c0, 1'b0, 1'b0);
      if (tbl[v].we1) step(1'b1, tbl[v].i1, tbl[v].c1, 1'b0, 1'b0);
      step(1'b0, '0, '0, tbl[v].upd, tbl[v].offr);
      chk($sformatf("v%0d_valid_after_edge1", v), valid, 0);
      @(negedge clk); #1;
      chk($sformatf("v%0d_valid_after_edge2", v), valid, 1);
      wait_frames(base + 1);
      check_frame($sformatf("v%0d", v), base, tbl[v].e0, tbl[v].e1);
    end

    step(1'b1, 2'd0, 24'hFF0000, 1'b0, 1'b0);
    step(1'b1, 2'd1, 24'h00FF00, 1'b0, 1'b0);

    // Writes and repeated updates while word 0 is in flight.
    base = frames.size();
    step(1'b0, '0, '0, 1'b1, 1'b0);
    wait_word(1'b0);
    step(1'b1, 2'd1, 24'h0000FF, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    wait_frames(base + 2);
    quiet(40);
    chk("coalesce_frame_count", frames.size(), base + 2);
    check_frame("coalesce_old", base, 24'h00FF00, 24'hFF0000);
    check_frame("coalesce_new", base + 1, 24'h00FF00, 24'h0000FF);

    // off then update while busy: one frame of programmed colours.
    base = frames.size();
    step(1'b0, '0, '0, 1'b1, 1'b0);
    wait_word(1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    wait_frames(base + 2);
    quiet(40);
    chk("off_then_upd_frame_count", frames.size(), base + 2);
    check_frame("off_then_upd", base + 1, 24'h00FF00, 24'h0000FF);

    // Idle bounces during the latch gap; the gap must restart.
    glitch = 1'b1;
    base = frames.size();
    step(1'b0, '0, '0, 1'b1, 1'b0);
    wait_frames(base + 1);
    glitch = 1'b0;
    check_frame("glitch_frame", base, 24'h00FF00, 24'h0000FF);

    // Asynchronous reset while the second word is presented.
    base = frames.size();
    step(1'b0, '0, '0, 1'b1, 1'b0);
    wait_word(1'b1);
    #1 rst = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    @(negedge clk); #1;
    rst = 1'b0;
    wait_frames(base + 1);
    check_frame("after_reset", base, 24'h000000, 24'h000000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d miscompares %0d", vecs, fails);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/rgbled_ctrl.md
Name: rgbled_ctrl

Overview:
- Sequences frames into the existing ws281x serial LED driver in place of a constant-data tie-off.
- Holds a programmable 24-bit colour per LED and streams one frame on request. Drives the driver's go/valid/last handshake, then enforces a latch gap before the next frame.
- Sits between a software-visible register block (the cfg_* and request ports) and ws281x_drv, in the main_clk_buf domain.

Parameters:
- NumLeds, 2: number of chained LEDs per frame; legal range 1..16.
- LatchCycles, 1600: minimum clk_i cycles after the driver reports idle before the next frame may start. 1600 cycles is 64 us at 25 MHz.
- IdxW, $clog2(NumLeds) (minimum 1): width of the LED index.

Ports:
- clk_i, input, 1: block clock.
- rst_i, input, 1: asynchronous, active-high reset.
- cfg_we_i, input, 1: write strobe for one colour entry.
- cfg_idx_i, input, IdxW: LED index for the write.
- cfg_rgb_i, input, 24: colour as {R[7:0],G[7:0],B[7:0]}.
- update_i, input, 1: single-cycle pulse; request a frame of the programmed colours.
- off_i, input, 1: single-cycle pulse; request a frame of all-zero colours.
- busy_o, output, 1: a frame or the latch gap is in progress.
- ws_go_o, output, 1: to driver go_i.
- ws_idle_i, input, 1: from driver idle_o.
- ws_data_o, output, 24: to driver data_i, ordered {G,R,B}.
- ws_data_valid_o, output, 1: to driver data_valid_i.
- ws_data_last_o, output, 1: to driver data_last_i.
- ws_data_ack_i, input, 1: from driver data_ack_o.

Behaviour:
- **Reset values.**
  - All colour registers are 0. State is IDLE and idx is 0. All outputs are 0.
  - pend_off=1 and pend_upd=0, so one all-zero frame is sent automatically after reset.
- **Colour writes.**
  - When cfg_we_i=1 and cfg_idx_i<NumLeds, colour[cfg_idx_i] takes cfg_rgb_i on the next edge.
  - When cfg_idx_i>=NumLeds the write is ignored.
  - Writes are accepted in every state.
- **Requests.** update_i sets pend_upd and clears pend_off; off_i sets pend_off and clears pend_upd. The last request wins. If both arrive in the same cycle, off wins. Repeated requests coalesce into one frame.
- **States:** IDLE, SEND, LATCH.
- **IDLE.**
  - busy_o=0.
  - If pend_off or pend_upd is set and ws_idle_i=1, on the next edge:
    - copy the frame into shadow[]: colour[] if pend_upd, zeros if pend_off;
    - clear both pend flags;
    - set idx=0 and go to SEND.
  - A request arriving in the same cycle as the start is held pending, not lost.
- **SEND.**
  - busy_o=1, ws_go_o=1, ws_data_valid_o=1.
  - ws_data_o={shadow[idx][15:8], shadow[idx][23:16], shadow[idx][7:0]}.
  - ws_data_last_o=(idx==NumLeds-1).
  - On ws_data_ack_i: if not last, idx increments; if last, go to LATCH and clear the latch counter.
  - Outputs are stable until ack. Writes to colour[] during SEND do not affect the frame in flight.
- **LATCH.**
  - busy_o=1; ws_go_o, ws_data_valid_o and ws_data_last_o are 0.
  - The counter holds at 0 while ws_idle_i=0, then increments each cycle while ws_idle_i=1.
  - When the counter reaches LatchCycles-1, go to IDLE. Total minimum gap is LatchCycles idle cycles.
  - If ws_idle_i drops during the count, the counter restarts.
- **NumLeds=1:** ws_data_last_o=1 for the only word.
- **Reset mid-frame:** everything returns to reset values asynchronously, including pend_off=1. The first frame after reset is zeros.
- **Latency:** with ws_idle_i=1, the first word is valid on the cycle after update_i is registered. That is 2 edges from the pulse: 1 to set pend, 1 to enter SEND.

Test Plan:
- Post-reset with the driver model idle:
  - exactly NumLeds=2 words of 24'h000000 are presented;
  - ws_data_last_o=1 only on the second word;
  - busy_o then drops after LATCH with LatchCycles=8, at least 8 cycles after ws_idle_i rises.
- Write idx0=24'hFF0000 and idx1=24'h00FF00, then pulse update_i:
  - ws_data_o shows 24'h00FF00 then 24'hFF0000 (GRB order);
  - each word is held until its ack.
- During SEND of word 0, write idx1=24'h0000FF and pulse update_i twice:
  - the current frame still sends the old idx1 value;
  - exactly one further frame follows, carrying 24'h0000FF.
- update_i and off_i in the same cycle -> an all-zero frame. Then off_i followed by update_i while busy -> exactly one frame, carrying colour[].
- Write with cfg_idx_i=3 (NumLeds=2) -> colour registers unchanged; the next frame matches the prior values.
- Assert rst_i while idx=1 in SEND:
  - all outputs are 0 in the same cycle;
  - after release, a zero frame is sent.
